qram_ddr_responder: RTL and testbench
=====================================

Name: qram_ddr_responder

Overview:
- Target (memory) end of the QRAM differential-DDR serial bit link.
- The initiator drives a differential strobe pair, a serial address bit, a serial write bit, and a write-enable level. This block recovers the strobe edges in the local clock domain and deserialises address and write data on both strobe edges.
- It stores write data in an internal word array. For read frames it serialises the addressed word back on QBitToRead.
- It sits between the link pins and the local QRAM storage, opposite the initiator.

Parameters:
- ADDR_W, 4, number of address bits per frame; array depth is 2**ADDR_W.
- DATA_W, 8, data bits per frame and word width.

Ports:
- Clock  in  1  system clock; all logic is on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- QRAM_DDRClockP  in  1  strobe, true leg; asynchronous to Clock.
- QRAM_DDRClockN  in  1  strobe, complement leg; asynchronous to Clock.
- AddressQBit  in  1  serial address, MSB first.
- QBitToWrite  in  1  serial write data, MSB first.
- WritingToQBit  in  1  frame type: 1 = write, 0 = read; sampled on the first address edge.
- QBitToRead  out  1  serial read data, MSB first.
- ReadActive  out  1  high while QBitToRead carries valid frame data.
- WriteDone  out  1  one-cycle pulse when a write commits to the array.
- ProtocolError  out  1  one-cycle pulse when a frame is aborted.

Behaviour:

Input capture and edge detection
- P, N, AddressQBit, QBitToWrite and WritingToQBit each pass through a 2-flop synchroniser.
- Pair state s = {P,N} after synchronisation.
- s=00 is idle. s=10 and s=01 are active. s=11 is illegal.
- An edge event is a one-cycle strobe generated when s changes 10->01 or 01->10. The data inputs are sampled in that same cycle, from their synchronised copies.
- Event latency is 3 Clock cycles from the pin change.
- The initiator holds each level for at least 4 Clock cycles, and holds data stable across each edge. The block is not required to handle faster strobes.

State machine: IDLE, ADDR, DATA, COMMIT
- IDLE: when s goes 00 -> active, move to ADDR with counter=0. This transition is not itself an edge.
- ADDR: each edge shifts AddressQBit into addr_sr. WritingToQBit is latched as is_wr on counter==0. After ADDR_W edges, move to DATA with counter=0.
  - Read frame: the array is read combinationally or registered at the ADDR->DATA transition. rd_sr loads the word, QBitToRead = rd_sr[DATA_W-1], and ReadActive=1 before the initiator's first data edge, which is ≥4 cycles later.
- DATA:
  - Write frame: each edge shifts QBitToWrite into wr_sr.
  - Read frame: each edge left-shifts rd_sr, so the next bit appears on QBitToRead 1 cycle after the edge.
  - After DATA_W edges: a write frame goes to COMMIT; a read frame drops ReadActive, drives QBitToRead=0, and returns to IDLE.
- COMMIT: mem[addr_sr] <= wr_sr, WriteDone=1 for one cycle, then IDLE.

Abort rules
- In ADDR or DATA, s==11 or s==00 aborts the frame: ProtocolError pulses 1 cycle, no array write occurs, ReadActive=0, and the state returns to IDLE.
- After an abort on s==11, leave IDLE only after s has passed through 00.
- In IDLE, s==11 is ignored; no error is raised.
- Extra edges after the last data edge and before s returns to 00 are ignored. While in IDLE with s active, no new frame starts until s goes 00 first.

Reset
- Reset sets the state to IDLE and clears the synchronisers, counters and shift registers.
- Outputs reset to QBitToRead=0, ReadActive=0, WriteDone=0, ProtocolError=0.
- Array contents are not reset.
- Reset asserted mid-frame discards the frame with no write and no error pulse.

Simultaneous events
- A reset in the same cycle as an edge: reset wins.
- An edge and an abort condition in the same cycle cannot occur, because an edge requires s active.

Test Plan:
- Write addr 0x5, data 0xA3 (4+8 edges, 6 cycles per level), then strobe 00 -> WriteDone pulses once; mem[5]=0xA3; ProtocolError stays 0.
- Read addr 0x5 after the write above -> ReadActive rises before data edge 0; QBitToRead sampled at each data edge gives 1,0,1,0,0,0,1,1; ReadActive=0 after edge 8.
- Write addr 0xF, data 0xFF, then write addr 0x0, data 0x00; read both -> returns 0xFF and 0x00. Checks address extremes and no aliasing.
- Write frame with s forced to 11 after data edge 3 -> ProtocolError 1-cycle pulse, no WriteDone, mem unchanged. A following valid frame succeeds only after s=00.
- Write frame where s drops to 00 after address edge 2 -> ProtocolError pulse; a subsequent read of the target address returns the old value.
- Assert Reset for 1 cycle during data edge 5 of a read -> ReadActive=0 and QBitToRead=0 next cycle, no error pulse; the next full frame works.

Source files
------------

// File: rtl/qram_ddr_responder.sv
// qram_ddr_responder
//   Target end of the QRAM differential-DDR serial bit link. The strobe pair
//   and serial data pins are synchronised into the Clock domain. Strobe
//   toggles between 10 and 01 are turned into one-cycle edge events. On each
//   edge one address bit and then one data bit is shifted in, MSB first.
//   Write frames commit the word to an internal array. Read frames serialise
//   the addressed word onto QBitToRead.
//
// Ports
//   Clock, Reset      system clock, synchronous active-high reset
//   QRAM_DDRClockP/N  strobe pair (async): 00 idle, 10/01 active, 11 illegal
//   AddressQBit       serial address bit, MSB first
//   QBitToWrite       serial write data bit, MSB first
//   WritingToQBit     frame type, taken on the first address edge (1 = write)
//   QBitToRead        serial read data, MSB first
//   ReadActive        high while QBitToRead carries frame data
//   WriteDone         one-cycle pulse after a word is written to the array
//   ProtocolError     one-cycle pulse when a frame is aborted
module qram_ddr_responder #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic Clock,
    input  logic Reset,
    input  logic QRAM_DDRClockP,
    input  logic QRAM_DDRClockN,
    input  logic AddressQBit,
    input  logic QBitToWrite,
    input  logic WritingToQBit,
    output logic QBitToRead,
    output logic ReadActive,
    output logic WriteDone,
    output logic ProtocolError
);

    localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W = $clog2(MAX_W + 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, COMMIT} state_t;

    // ------------------------------------------------------------------
    // Input synchronisers: {P, N, addr, wdata, wr}
    // ------------------------------------------------------------------
    logic [4:0] sync1, sync2;
    logic [1:0] sync_vld;   // marks when sync2 holds pin data, not reset flush
    logic [1:0] s, s_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync1    <= '0;
            sync2    <= '0;
            sync_vld <= '0;
            s_q      <= '0;
        end else begin
            sync1    <= {QRAM_DDRClockP, QRAM_DDRClockN, AddressQBit,
                         QBitToWrite, WritingToQBit};
            sync2    <= sync1;
            sync_vld <= {sync_vld[0], 1'b1};
            s_q      <= s;
        end
    end

    logic s_ok, s_active, s_idle, s_bad, edge_ev;
    logic a_bit, d_bit, w_bit;

    always_comb begin
        s        = sync2[4:3];
        a_bit    = sync2[2];
        d_bit    = sync2[1];
        w_bit    = sync2[0];
        // The two flushed reset cycles would otherwise look like a real 00
        // and could arm a frame start in the middle of an initiator frame.
        s_ok     = sync_vld[1];
        s_active = s_ok && (s == 2'b10 || s == 2'b01);
        s_idle   = s_ok && (s == 2'b00);
        s_bad    = s_ok && (s == 2'b00 || s == 2'b11);
        // An edge is a direct swap between the two active codes.
        edge_ev  = s_active && (s_q == ~s);
    end

    // ------------------------------------------------------------------
    // Frame state
    // ------------------------------------------------------------------
    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [ADDR_W-1:0]   addr_sr, addr_nxt;
    logic [DATA_W-1:0]   wr_sr, rd_sr;
    logic                is_wr, wr_flag, read_active;
    logic                armed;    // s has been seen at 00 since the last start
    logic                abort, start, last_addr, last_data;
    logic                error_q, done_q;
    logic [DATA_W-1:0]   mem [2**ADDR_W];

    always_comb begin
        last_addr = (cnt == CNT_W'(ADDR_W - 1));
        last_data = (cnt == CNT_W'(DATA_W - 1));
        addr_nxt  = (addr_sr << 1) | ADDR_W'(a_bit);
        // The frame type is not registered until the first address edge ends.
        wr_flag   = (cnt == '0) ? w_bit : is_wr;
    end

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        abort     = 1'b0;
        start     = 1'b0;
        case (state)
            IDLE: begin
                // A frame starts only on 00 -> active; s = 11 here is ignored.
                if (armed && s_active) begin
                    start     = 1'b1;
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                if (s_bad) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end else if (edge_ev && last_addr) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (s_bad) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end else if (edge_ev && last_data) begin
                    state_nxt = is_wr ? COMMIT : IDLE;
                end
            end
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: counters, shift registers, pulse registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt         <= '0;
            addr_sr     <= '0;
            wr_sr       <= '0;
            rd_sr       <= '0;
            is_wr       <= 1'b0;
            read_active <= 1'b0;
            armed       <= 1'b0;
            error_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            error_q <= abort;
            done_q  <= (state == COMMIT);

            if (s_idle)     armed <= 1'b1;
            else if (start) armed <= 1'b0;

            case (state)
                IDLE: cnt <= '0;
                ADDR: begin
                    if (edge_ev) begin
                        addr_sr <= addr_nxt;
                        if (cnt == '0) is_wr <= w_bit;
                        if (last_addr) begin
                            cnt <= '0;
                            // Read word is staged a full strobe level before
                            // the first data edge.
                            if (!wr_flag) begin
                                rd_sr       <= mem[addr_nxt];
                                read_active <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                DATA: begin
                    if (edge_ev) begin
                        if (is_wr) wr_sr <= (wr_sr << 1) | DATA_W'(d_bit);
                        else       rd_sr <= rd_sr << 1;
                        cnt <= cnt + CNT_W'(1);
                        if (last_data) begin
                            read_active <= 1'b0;
                            rd_sr       <= '0;
                        end
                    end
                end
                default: ;
            endcase

            if (abort) begin
                read_active <= 1'b0;
                rd_sr       <= '0;
            end
        end
    end

    // Storage array; contents survive reset, and a reset in the commit
    // cycle suppresses the write.
    always_ff @(posedge Clock) begin
        if (!Reset && state == COMMIT) mem[addr_sr] <= wr_sr;
    end

    // Outputs
    always_comb begin
        QBitToRead    = read_active & rd_sr[DATA_W-1];
        ReadActive    = read_active;
        WriteDone     = done_q;
        ProtocolError = error_q;
    end

endmodule

// File: tb/tb_qram_ddr_responder.sv
module tb_qram_ddr_responder;

    logic clk = 1'b0;
    logic rst;
    logic p, n, a, d, w;
    logic q, ra, wd, pe;

    int errors = 0;
    int checks = 0;
    int wd_cnt = 0;
    int pe_cnt = 0;
    bit ph;
    int wd0, pe0;

    qram_ddr_responder #(.ADDR_W(4), .DATA_W(8)) dut (
        .Clock(clk), .Reset(rst),
        .QRAM_DDRClockP(p), .QRAM_DDRClockN(n),
        .AddressQBit(a), .QBitToWrite(d), .WritingToQBit(w),
        .QBitToRead(q), .ReadActive(ra), .WriteDone(wd), .ProtocolError(pe)
    );

    always #5 clk = ~clk;

    // Pulse counters: each registered pulse is high for exactly one cycle.
    always @(negedge clk) begin
        if (wd === 1'b1) wd_cnt++;
        if (pe === 1'b1) pe_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", name, obs, exp);
        end
    endtask

    // Drive one strobe level with its data, hold it for 6 cycles.
    task automatic lvl(input logic [1:0] s, input logic ab, input logic db, input logic wb);
        p = s[1]; n = s[0]; a = ab; d = db; w = wb;
        repeat (6) @(negedge clk);
    endtask

    task automatic start_lvl();
        ph = 1'b1;
        lvl(2'b10, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic edge_lvl(input logic ab, input logic db, input logic wb);
        ph = ~ph;
        lvl(ph ? 2'b10 : 2'b01, ab, db, wb);
    endtask

    task automatic idle_lvl();
        lvl(2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    // Start plus na address edges and nd data edges, no trailing idle.
    task automatic frame(input logic [3:0] addr, input logic [7:0] data,
                         input logic wb, input int na, input int nd);
        start_lvl();
        for (int i = 0; i < na; i++) edge_lvl(addr[3-i], 1'b0, wb);
        for (int i = 0; i < nd; i++) edge_lvl(1'b0, data[7-i], wb);
    endtask

    task automatic write_frame(input logic [3:0] addr, input logic [7:0] data);
        frame(addr, data, 1'b1, 4, 8);
        idle_lvl();
    endtask

    // Read with nd data edges; QBitToRead is checked just before each edge.
    task automatic read_frame(input string tag, input logic [3:0] addr,
                              input logic [7:0] exp, input int nd);
        frame(addr, 8'h00, 1'b0, 4, 0);
        chk({tag, "_ra_pre"}, 32'(ra), 32'd1);
        for (int i = 0; i < nd; i++) begin
            chk($sformatf("%s_bit%0d", tag, i), 32'(q), 32'(exp[7-i]));
            edge_lvl(1'b0, 1'b0, 1'b0);
        end
        if (nd == 8) begin
            chk({tag, "_ra_post"}, 32'(ra), 32'd0);
            chk({tag, "_q_post"}, 32'(q), 32'd0);
            idle_lvl();
        end
    endtask

    initial begin
        rst = 1'b1; p = 0; n = 0; a = 0; d = 0; w = 0;
        repeat (4) @(negedge clk);
        chk("rst_q",  32'(q),  32'd0);
        chk("rst_ra", 32'(ra), 32'd0);
        chk("rst_wd", 32'(wd), 32'd0);
        chk("rst_pe", 32'(pe), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Basic write then read back
        write_frame(4'h5, 8'hA3);
        chk("wr5_done", 32'(wd_cnt), 32'd1);
        chk("wr5_noerr", 32'(pe_cnt), 32'd0);
        read_frame("rd5", 4'h5, 8'hA3, 8);

        // Address extremes, no aliasing
        write_frame(4'hF, 8'hFF);
        write_frame(4'h0, 8'h00);
        chk("ext_done", 32'(wd_cnt), 32'd3);
        read_frame("rdF", 4'hF, 8'hFF, 8);
        read_frame("rd0", 4'h0, 8'h00, 8);
        read_frame("rd5b", 4'h5, 8'hA3, 8);

        // Abort with s = 11 after data edge 3
        wd0 = wd_cnt; pe0 = pe_cnt;
        frame(4'h5, 8'h3C, 1'b1, 4, 4);
        lvl(2'b11, 1'b0, 1'b0, 1'b0);
        chk("ab11_err", 32'(pe_cnt), 32'(pe0 + 1));
        chk("ab11_nowd", 32'(wd_cnt), 32'(wd0));
        // Leaving 11 straight into an active level must not start a frame
        frame(4'h5, 8'h11, 1'b1, 4, 8);
        idle_lvl();
        chk("ab11_noframe_wd", 32'(wd_cnt), 32'(wd0));
        chk("ab11_noframe_pe", 32'(pe_cnt), 32'(pe0 + 1));
        write_frame(4'h6, 8'h5A);
        chk("ab11_next_wd", 32'(wd_cnt), 32'(wd0 + 1));
        read_frame("rd5c", 4'h5, 8'hA3, 8);
        read_frame("rd6", 4'h6, 8'h5A, 8);

        // Strobe drops to 00 after address edge 2
        wd0 = wd_cnt; pe0 = pe_cnt;
        frame(4'hF, 8'h12, 1'b1, 3, 0);
        idle_lvl();
        chk("ab00_err", 32'(pe_cnt), 32'(pe0 + 1));
        chk("ab00_nowd", 32'(wd_cnt), 32'(wd0));
        read_frame("rdF2", 4'hF, 8'hFF, 8);

        // Reset during data edge 5 of a read
        wd0 = wd_cnt; pe0 = pe_cnt;
        read_frame("rdrst", 4'h5, 8'hA3, 5);
        ph = ~ph;
        p = ph; n = ~ph;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_ra", 32'(ra), 32'd0);
        chk("rst_mid_q",  32'(q),  32'd0);
        @(negedge clk);
        edge_lvl(1'b0, 1'b0, 1'b0);
        edge_lvl(1'b0, 1'b0, 1'b0);
        idle_lvl();
        chk("rst_mid_pe", 32'(pe_cnt), 32'(pe0));
        chk("rst_mid_ra2", 32'(ra), 32'd0);
        write_frame(4'h3, 8'h96);
        chk("post_rst_wd", 32'(wd_cnt), 32'(wd0 + 1));
        read_frame("rd3", 4'h3, 8'h96, 8);
        chk("final_pe", 32'(pe_cnt), 32'(pe0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
